// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
// Holds the state encoding, the supported opcodes, the ALU and mux select
// encodings, and the raw control word that the output decoder hands to the
// top. The top then gates that word with mem_ready, zero and rst.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    REXEC  = 4'd6,
    RWB    = 4'd7,
    BEQEX  = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JEX    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Raw per-state control word. 'fetch' marks the state whose IR load and
  // PC advance are qualified by mem_ready; 'pc_write' is an unconditional
  // PC write; 'branch' is qualified by the ALU zero flag.
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       fetch;
    logic       pc_write;
    logic       branch;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

endpackage

// File: rtl/mips_mc_control_if.sv
// Control <-> datapath bundle for the multicycle MIPS control unit.
// master: the control FSM (consumes opcode/zero/mem_ready, drives controls).
// slave : the datapath/memory side.
interface mips_mc_control_if #(
  parameter int OPCODE_WIDTH = 6
);
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    zero;
  logic                    mem_ready;
  logic                    pc_en;
  logic                    iord;
  logic                    mem_read;
  logic                    mem_write;
  logic                    ir_write;
  logic                    reg_dst;
  logic                    mem_to_reg;
  logic                    reg_write;
  logic                    alu_src_a;
  logic [1:0]              alu_src_b;
  logic [1:0]              alu_op;
  logic [1:0]              pc_src;
  logic                    illegal;
  logic                    mem_timeout;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal, mem_timeout
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal, mem_timeout
  );
endinterface

// File: rtl/mips_mc_outdec.sv
// Combinational state -> raw control word decoder (pure Moore decode).
// Ports: state (current FSM state), ctrl (raw control word, ungated).
module mips_mc_outdec
  import mips_mc_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.fetch     = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
      end
      DECODE: begin
        // Branch target is precomputed here while the opcode is decoded.
        ctrl.alu_src_b = SRCB_IMMSH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEMADR, ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      REXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      BEQEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.branch    = 1'b1;
      end
      ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      JEX: begin
        ctrl.pc_src   = PCSRC_JUMP;
        ctrl.pc_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end
endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM.
// Ports: clk, rst (async, active-high), bus (master side of
// mips_mc_control_if: opcode/zero/mem_ready in, datapath controls out).
// Holds the state register, next-state logic, the memory wait counter and
// the gating of PC/IR enables with mem_ready, zero and rst.
module mips_mc_control
  import mips_mc_pkg::*;
#(
  parameter int OPCODE_WIDTH = 6,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                rst,
  mips_mc_control_if.master   bus
);
  localparam int CW = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT_MAX - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] wait_cnt_reg;
  ctrl_t         ctrl;
  logic          in_wait;
  logic          bad_op;
  logic          timeout;

  mips_mc_outdec u_outdec (
    .state (state_reg),
    .ctrl  (ctrl)
  );

  always_comb begin
    state_next = state_reg;
    in_wait    = 1'b0;
    bad_op     = 1'b0;
    case (state_reg)
      FETCH: begin
        in_wait = 1'b1;
        if (bus.mem_ready) state_next = DECODE;
      end
      DECODE: begin
        if (bus.opcode == OPCODE_WIDTH'(OP_LW) || bus.opcode == OPCODE_WIDTH'(OP_SW))
          state_next = MEMADR;
        else if (bus.opcode == OPCODE_WIDTH'(OP_RTYPE)) state_next = REXEC;
        else if (bus.opcode == OPCODE_WIDTH'(OP_BEQ))   state_next = BEQEX;
        else if (bus.opcode == OPCODE_WIDTH'(OP_ADDI))  state_next = ADDIEX;
        else if (bus.opcode == OPCODE_WIDTH'(OP_J))     state_next = JEX;
        else begin
          state_next = FETCH;
          bad_op     = 1'b1;
        end
      end
      MEMADR: state_next = (bus.opcode == OPCODE_WIDTH'(OP_SW)) ? MEMWR : MEMRD;
      MEMRD: begin
        in_wait = 1'b1;
        if (bus.mem_ready) state_next = MEMWB;
      end
      MEMWR: begin
        in_wait = 1'b1;
        if (bus.mem_ready) state_next = FETCH;
      end
      REXEC:  state_next = RWB;
      ADDIEX: state_next = ADDIWB;
      default: state_next = FETCH;
    endcase
    // The counter holds the number of earlier stalled cycles, so this is
    // the MEM_WAIT_MAX-th stalled cycle. A completing access wins.
    timeout = in_wait && !bus.mem_ready && (wait_cnt_reg == WAIT_LAST);
    if (timeout) state_next = FETCH;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= FETCH;
      wait_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (timeout || state_next != state_reg)
        wait_cnt_reg <= '0;
      else if (in_wait && !bus.mem_ready)
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end

  // Enables and strobes are masked by rst directly: the FETCH decode would
  // otherwise raise pc_en/ir_write/mem_read while reset is held.
  assign bus.pc_en       = ~rst & (ctrl.pc_write | (ctrl.fetch & bus.mem_ready)
                                   | (ctrl.branch & bus.zero));
  assign bus.ir_write    = ~rst & ctrl.fetch & bus.mem_ready;
  assign bus.mem_read    = ~rst & ctrl.mem_read;
  assign bus.mem_write   = ~rst & ctrl.mem_write;
  assign bus.reg_write   = ~rst & ctrl.reg_write;
  assign bus.illegal     = ~rst & bad_op;
  assign bus.mem_timeout = ~rst & timeout;

  assign bus.iord       = ctrl.iord;
  assign bus.reg_dst    = ctrl.reg_dst;
  assign bus.mem_to_reg = ctrl.mem_to_reg;
  assign bus.alu_src_a  = ctrl.alu_src_a;
  assign bus.alu_src_b  = ctrl.alu_src_b;
  assign bus.alu_op     = ctrl.alu_op;
  assign bus.pc_src     = ctrl.pc_src;
endmodule

// File: tb/tb_mips_mc_control.sv
// Testbench for mips_mc_control: a per-cycle vector table (state the DUT
// should be in, inputs, explicit illegal/timeout/reset flags) is expanded
// into expected control words, pushed to a scoreboard queue when the
// inputs are driven and popped when outputs are sampled mid-cycle.
module tb_mips_mc_control;

  localparam int T_FETCH = 0, T_DECODE = 1, T_MEMADR = 2, T_MEMRD = 3,
                 T_MEMWB = 4, T_MEMWR = 5, T_REXEC = 6, T_RWB = 7,
                 T_BEQEX = 8, T_ADDIEX = 9, T_ADDIWB = 10, T_JEX = 11;

  localparam logic [5:0] O_R = 6'b000000, O_LW = 6'b100011, O_SW = 6'b101011,
                         O_BEQ = 6'b000100, O_ADDI = 6'b001000, O_J = 6'b000010,
                         O_BAD = 6'b111111;

  typedef struct packed {
    logic       pc_en;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal;
    logic       mem_timeout;
  } cw_t;

  typedef struct {
    int         st;
    logic [5:0] op;
    bit         mr;
    bit         z;
    bit         ill;
    bit         to;
    bit         r;
    string      tag;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips_mc_control_if #(.OPCODE_WIDTH(6)) bus ();

  mips_mc_control #(.OPCODE_WIDTH(6), .MEM_WAIT_MAX(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  vec_t vecs[$];
  cw_t  exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic add(input int st, input logic [5:0] op, input bit mr,
                     input bit z, input bit ill, input bit to, input bit r,
                     input string tag);
    vec_t v;
    v.st = st; v.op = op; v.mr = mr; v.z = z; v.ill = ill; v.to = to; v.r = r;
    v.tag = tag;
    vecs.push_back(v);
  endtask

  task automatic add_n(input int n, input int st, input logic [5:0] op,
                       input bit mr, input string tag);
    for (int k = 0; k < n; k++) add(st, op, mr, 0, 0, 0, 0, tag);
  endtask

  // Expected control word straight from the per-state output table.
  function automatic cw_t exp_cw(input vec_t v);
    cw_t c;
    c = '0;
    case (v.st)
      T_FETCH:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.pc_en = v.mr; c.ir_write = v.mr; end
      T_DECODE: c.alu_src_b = 2'b11;
      T_MEMADR: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      T_MEMRD:  begin c.mem_read = 1; c.iord = 1; end
      T_MEMWB:  begin c.reg_write = 1; c.mem_to_reg = 1; end
      T_MEMWR:  begin c.mem_write = 1; c.iord = 1; end
      T_REXEC:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      T_RWB:    begin c.reg_write = 1; c.reg_dst = 1; end
      T_BEQEX:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.pc_en = v.z; end
      T_ADDIEX: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      T_ADDIWB: c.reg_write = 1;
      T_JEX:    begin c.pc_src = 2'b10; c.pc_en = 1; end
      default:  c = '0;
    endcase
    c.illegal     = v.ill;
    c.mem_timeout = v.to;
    if (v.r) begin
      c = '0;
      c.alu_src_b = 2'b01;
    end
    return c;
  endfunction

  function automatic cw_t sample();
    cw_t a;
    a.pc_en = bus.pc_en; a.ir_write = bus.ir_write; a.reg_write = bus.reg_write;
    a.mem_read = bus.mem_read; a.mem_write = bus.mem_write; a.iord = bus.iord;
    a.reg_dst = bus.reg_dst; a.mem_to_reg = bus.mem_to_reg;
    a.alu_src_a = bus.alu_src_a; a.alu_src_b = bus.alu_src_b;
    a.alu_op = bus.alu_op; a.pc_src = bus.pc_src; a.illegal = bus.illegal;
    a.mem_timeout = bus.mem_timeout;
    return a;
  endfunction

  initial begin
    bus.opcode    = O_R;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;

    // Reset held with mem_ready high and an R-type opcode.
    for (int k = 0; k < 3; k++) add(T_FETCH, O_R, 1, 0, 0, 0, 1, "reset");
    add(T_FETCH, O_LW, 1, 0, 0, 0, 0, "rst_release_fetch");
    // lw: 5 cycles.
    add(T_DECODE, O_LW, 1, 0, 0, 0, 0, "lw_decode");
    add(T_MEMADR, O_LW, 1, 0, 0, 0, 0, "lw_memadr");
    add(T_MEMRD,  O_LW, 1, 0, 0, 0, 0, "lw_memrd");
    add(T_MEMWB,  O_LW, 1, 0, 0, 0, 0, "lw_memwb");
    // sw: 4 cycles.
    add(T_FETCH,  O_SW, 1, 0, 0, 0, 0, "sw_fetch");
    add(T_DECODE, O_SW, 1, 0, 0, 0, 0, "sw_decode");
    add(T_MEMADR, O_SW, 1, 0, 0, 0, 0, "sw_memadr");
    add(T_MEMWR,  O_SW, 1, 0, 0, 0, 0, "sw_memwr");
    // R-type and addi.
    add(T_FETCH,  O_R, 1, 0, 0, 0, 0, "r_fetch");
    add(T_DECODE, O_R, 1, 0, 0, 0, 0, "r_decode");
    add(T_REXEC,  O_R, 1, 0, 0, 0, 0, "r_exec");
    add(T_RWB,    O_R, 1, 0, 0, 0, 0, "r_wb");
    add(T_FETCH,  O_ADDI, 1, 0, 0, 0, 0, "addi_fetch");
    add(T_DECODE, O_ADDI, 1, 0, 0, 0, 0, "addi_decode");
    add(T_ADDIEX, O_ADDI, 1, 0, 0, 0, 0, "addi_exec");
    add(T_ADDIWB, O_ADDI, 1, 0, 0, 0, 0, "addi_wb");
    // beq taken then not taken.
    add(T_FETCH,  O_BEQ, 1, 1, 0, 0, 0, "beq1_fetch");
    add(T_DECODE, O_BEQ, 1, 1, 0, 0, 0, "beq1_decode");
    add(T_BEQEX,  O_BEQ, 1, 1, 0, 0, 0, "beq1_taken");
    add(T_FETCH,  O_BEQ, 1, 0, 0, 0, 0, "beq0_fetch");
    add(T_DECODE, O_BEQ, 1, 0, 0, 0, 0, "beq0_decode");
    add(T_BEQEX,  O_BEQ, 1, 0, 0, 0, 0, "beq0_not_taken");
    // Fetch stalled 3 cycles, then a jump.
    add_n(3, T_FETCH, O_J, 0, "fetch_stall");
    add(T_FETCH,  O_J, 1, 0, 0, 0, 0, "fetch_done");
    add(T_DECODE, O_J, 1, 0, 0, 0, 0, "j_decode");
    add(T_JEX,    O_J, 1, 0, 0, 0, 0, "j_exec");
    // Unsupported opcode.
    add(T_FETCH,  O_BAD, 1, 0, 0, 0, 0, "bad_fetch");
    add(T_DECODE, O_BAD, 1, 0, 1, 0, 0, "bad_decode");
    // lw with a 2-cycle data stall.
    add(T_FETCH,  O_LW, 1, 0, 0, 0, 0, "lw2_fetch");
    add(T_DECODE, O_LW, 1, 0, 0, 0, 0, "lw2_decode");
    add(T_MEMADR, O_LW, 1, 0, 0, 0, 0, "lw2_memadr");
    add_n(2, T_MEMRD, O_LW, 0, "lw2_memrd_stall");
    add(T_MEMRD,  O_LW, 1, 0, 0, 0, 0, "lw2_memrd_done");
    add(T_MEMWB,  O_LW, 1, 0, 0, 0, 0, "lw2_memwb");
    // sw stalled until timeout; retried fetch afterwards has mem_write low.
    add(T_FETCH,  O_SW, 1, 0, 0, 0, 0, "swto_fetch");
    add(T_DECODE, O_SW, 1, 0, 0, 0, 0, "swto_decode");
    add(T_MEMADR, O_SW, 1, 0, 0, 0, 0, "swto_memadr");
    add_n(14, T_MEMWR, O_SW, 0, "swto_wait");
    add(T_MEMWR,  O_SW, 0, 0, 0, 1, 0, "swto_timeout");
    add(T_FETCH,  O_SW, 0, 0, 0, 0, 0, "swto_after");
    add(T_FETCH,  O_SW, 1, 0, 0, 0, 0, "sw3_fetch");
    add(T_DECODE, O_SW, 1, 0, 0, 0, 0, "sw3_decode");
    add(T_MEMADR, O_SW, 1, 0, 0, 0, 0, "sw3_memadr");
    // Completion on the limit cycle beats the timeout.
    add_n(14, T_MEMWR, O_SW, 0, "swlim_wait");
    add(T_MEMWR,  O_SW, 1, 0, 0, 0, 0, "swlim_complete");
    // Fetch timeout, then a fresh full wait window proves the counter cleared.
    add_n(14, T_FETCH, O_R, 0, "fto_wait");
    add(T_FETCH,  O_R, 0, 0, 0, 1, 0, "fto_timeout");
    add_n(14, T_FETCH, O_R, 0, "fto_rewait");
    add(T_FETCH,  O_R, 1, 0, 0, 0, 0, "fto_done");
    add(T_DECODE, O_R, 1, 0, 0, 0, 0, "r2_decode");
    add(T_REXEC,  O_R, 1, 0, 0, 0, 0, "r2_exec");
    add(T_RWB,    O_R, 1, 0, 0, 0, 0, "r2_wb");
    // Reset in the middle of an sw: no write, resumes in FETCH.
    add(T_FETCH,  O_SW, 1, 0, 0, 0, 0, "swr_fetch");
    add(T_DECODE, O_SW, 1, 0, 0, 0, 0, "swr_decode");
    add(T_MEMADR, O_SW, 1, 0, 0, 0, 0, "swr_memadr");
    add(T_FETCH,  O_SW, 1, 0, 0, 0, 1, "swr_reset");
    add(T_FETCH,  O_SW, 1, 0, 0, 0, 1, "swr_reset");
    add(T_FETCH,  O_ADDI, 1, 0, 0, 0, 0, "post_rst_fetch");
    add(T_DECODE, O_ADDI, 1, 0, 0, 0, 0, "post_rst_decode");
    add(T_ADDIEX, O_ADDI, 1, 0, 0, 0, 0, "post_rst_exec");

    foreach (vecs[i]) begin
      cw_t act, exp_w;
      @(negedge clk);
      rst           = vecs[i].r;
      bus.opcode    = vecs[i].op;
      bus.zero      = vecs[i].z;
      bus.mem_ready = vecs[i].mr;
      exp_q.push_back(exp_cw(vecs[i]));
      #2;
      act   = sample();
      exp_w = exp_q.pop_front();
      n_checks++;
      if (act === exp_w) begin
        n_pass++;
        $display("[%0t] %s op=%b mr=%0d z=%0d rst=%0d ctrl=%h ok", $time,
                 vecs[i].tag, vecs[i].op, vecs[i].mr, vecs[i].z, vecs[i].r, act);
      end else begin
        $display("[%0t] FAIL %s ctrl actual=%h required=%h", $time,
                 vecs[i].tag, act, exp_w);
      end
    end

    if (n_checks != vecs.size())
      $display("FAIL check count %0d does not match vector count %0d",
               n_checks, vecs.size());
    if (exp_q.size() != 0)
      $display("FAIL scoreboard not drained: %0d entries left", exp_q.size());
    if (n_pass == n_checks)
      $display("PASS %0d/%0d checks passed", n_pass, n_checks);
    else
      $display("FAIL %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d checks done", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
